// File: rtl/rr_packet_arbiter.sv
// N-way round-robin arbiter that holds each grant for a whole packet until release.
// Optional ARB_BACK_TO_BACK_EN re-arbitrates on the release edge, removing the idle bubble.
module rr_packet_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             release_i,
  output logic             grant_valid_o,
  output logic [N_REQ-1:0] grant_onehot_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             locked_o
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_REQ-1:0] onehot_q, onehot_d;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] search_ptr;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_found;

  // Explicit wrap so non-power-of-two N_REQ never lets the pointer escape the range.
  assign next_ptr = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;

`ifdef ARB_BACK_TO_BACK_EN
  assign search_ptr = (state_q == StBusy) ? next_ptr : ptr_q;
`else
  assign search_ptr = ptr_q;
`endif

  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      if (32'(search_ptr) + off >= N_REQ) begin
        cand = IDX_W'(32'(search_ptr) + off - N_REQ);
      end else begin
        cand = IDX_W'(32'(search_ptr) + off);
      end
      if (!arb_found && req_i[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          state_d  = StBusy;
          idx_d    = arb_idx;
          onehot_d = N_REQ'(1) << arb_idx;
        end
      end
      StBusy: begin
        if (release_i) begin
          state_d  = StIdle;
          ptr_d    = next_ptr;
          onehot_d = '0;
`ifdef ARB_BACK_TO_BACK_EN
          if (arb_found) begin
            state_d  = StBusy;
            idx_d    = arb_idx;
            onehot_d = N_REQ'(1) << arb_idx;
          end
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      idx_q    <= '0;
      onehot_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
    end
  end

  assign grant_valid_o  = (state_q == StBusy);
  assign locked_o       = (state_q == StBusy);
  assign grant_onehot_o = onehot_q;
  assign grant_idx_o    = idx_q;

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Scoreboard bench: stimulus queues expected grant indices, a negedge monitor checks each new grant.
module tb_rr_packet_arbiter;

`ifdef ARB_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       rel;
  logic       gv;
  logic [3:0] goh;
  logic [1:0] gidx;
  logic       lk;

  logic [2:0] req3;
  logic       rel3;
  logic       gv3;
  logic [2:0] goh3;
  logic [1:0] gidx3;
  logic       lk3;

  int checks;
  int errors;
  int exp_q[$];

  rr_packet_arbiter #(.N_REQ(4), .IDX_W(2)) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .req_i         (req),
    .release_i     (rel),
    .grant_valid_o (gv),
    .grant_onehot_o(goh),
    .grant_idx_o   (gidx),
    .locked_o      (lk)
  );

  rr_packet_arbiter #(.N_REQ(3), .IDX_W(2)) dut3 (
    .clk_i         (clk),
    .reset_i       (reset),
    .req_i         (req3),
    .release_i     (rel3),
    .grant_valid_o (gv3),
    .grant_onehot_o(goh3),
    .grant_idx_o   (gidx3),
    .locked_o      (lk3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Stimulus time point: just after the falling edge, outputs settled from the last rising edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_grant(input string name);
    int n = 0;
    while (!gv && n < 10) begin
      tick();
      n++;
    end
    if (!gv) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout got grant_valid 0 expected 1", name);
    end
  endtask

  task automatic wait_grant3(input string name);
    int n = 0;
    while (!gv3 && n < 10) begin
      tick();
      n++;
    end
    if (!gv3) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout got grant_valid 0 expected 1", name);
    end
  endtask

  // Release the current grant while presenting next_req; checks the cycle after the release edge.
  task automatic release_with(input logic [3:0] next_req, input string name);
    rel = 1'b1;
    req = next_req;
    tick();
    rel = 1'b0;
    check({name, "_valid"}, int'(gv), int'(B2B && next_req != 4'b0));
    check({name, "_locked"}, int'(lk), int'(gv));
  endtask

  // Monitor: a new grant appears after idle, or directly after a release edge.
  initial begin
    logic prev_v;
    logic prev_r;
    int   e;
    prev_v = 1'b0;
    prev_r = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_v = 1'b0;
        prev_r = 1'b0;
      end else begin
        if (gv && (!prev_v || prev_r)) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_grant: got idx %0d expected no grant", gidx);
          end else begin
            e = exp_q.pop_front();
            check("grant_idx", int'(gidx), e);
            check("grant_onehot", int'(goh), 1 << e);
          end
        end
        prev_v = gv;
        prev_r = rel && gv;
      end
    end
  end

  initial begin
    int seq3[4];
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    req    = 4'b0;
    rel    = 1'b0;
    req3   = 3'b0;
    rel3   = 1'b0;
    tick();
    tick();
    check("rst_valid", int'(gv), 0);
    check("rst_onehot", int'(goh), 0);
    check("rst_idx", int'(gidx), 0);
    check("rst_locked", int'(lk), 0);
    check("rst3_valid", int'(gv3), 0);
    reset = 1'b0;

    // Grant held for five cycles with req dropped and no release.
    exp_q.push_back(0);
    req = 4'b0001;
    wait_grant("t1_grant");
    req = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t1_hold_valid", int'(gv), 1);
      check("t1_hold_onehot", int'(goh), 1);
    end
    release_with(4'b0000, "t1_rel");
    check("t1_idx_kept", int'(gidx), 0);

    // Full rotation from ptr 0.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(0);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_grant("t2_grant");
      release_with((i == 4) ? 4'b0000 : 4'b1111, "t2_rel");
    end

    // ptr=1 now: grant 1, then 1010 from ptr 2 gives 3, then wraps to give 1.
    exp_q.push_back(1);
    req = 4'b0010;
    wait_grant("t3_a");
    release_with(4'b0000, "t3_a_rel");
    exp_q.push_back(3);
    req = 4'b1010;
    wait_grant("t3_b");
    release_with(4'b0000, "t3_b_rel");
    exp_q.push_back(1);
    req = 4'b1010;
    wait_grant("t3_c");
    release_with(4'b0000, "t3_c_rel");

    // Release while idle must not move ptr (still 2).
    rel = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("t4_idle_valid", int'(gv), 0);
      check("t4_idle_idx", int'(gidx), 1);
    end
    rel = 1'b0;
    exp_q.push_back(2);
    req = 4'b1111;
    wait_grant("t4_grant");

    // Asynchronous reset between edges while holding idx 2.
    #2;
    reset = 1'b1;
    #1;
    check("t5_async_valid", int'(gv), 0);
    check("t5_async_onehot", int'(goh), 0);
    check("t5_async_locked", int'(lk), 0);
    check("t5_async_idx", int'(gidx), 0);
    req = 4'b0000;
    tick();
    reset = 1'b0;
    exp_q.push_back(0);
    req = 4'b1111;
    wait_grant("t5_grant");
    release_with(4'b0000, "t5_rel");

    // ptr=1: release and new request on the same edge; release wins, 0100 granted next.
    exp_q.push_back(0);
    exp_q.push_back(2);
    req = 4'b0001;
    wait_grant("t6_a");
    release_with(4'b0100, "t6_a_rel");
    wait_grant("t6_b");
    release_with(4'b0000, "t6_b_rel");

    // ptr=3: sole requester 0 is re-granted after its own release.
    exp_q.push_back(0);
    exp_q.push_back(0);
    req = 4'b0001;
    wait_grant("t7_a");
    release_with(4'b0001, "t7_a_rel");
    wait_grant("t7_b");
    release_with(4'b0000, "t7_b_rel");

    // Three requesters: rotation must wrap 2 -> 0.
    seq3 = '{0, 1, 2, 0};
    req3 = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_grant3("n3_grant");
      check("n3_idx", int'(gidx3), seq3[i]);
      check("n3_onehot", int'(goh3), 1 << seq3[i]);
      rel3 = 1'b1;
      if (i == 3) req3 = 3'b000;
      tick();
      rel3 = 1'b0;
      check("n3_rel_valid", int'(gv3), int'(B2B && req3 != 3'b0));
    end

    tick();
    tick();
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
